// File: rtl/uart_pkg.sv
// Shared UART types and constants for the ALU-facing serial port.
// Both TX and RX FSMs walk the same IDLE/START/DATA/STOP sequence.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uartState_t;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int BIT_CNT_W        = $clog2(CLKS_PER_BIT_DEF);
endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 deserializer: 2-FF synchronizer, start-glitch reject, stop-bit framing check.
// Byte/error strobe one cycle after the stop-bit mid sample; no backpressure, consumer must take the strobe.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uartRx,
    output logic [7:0] rxByte,
    output logic       rxByteVld,
    output logic       rxFrameErr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rxMeta, rxSync, rxPrev;
    uartState_t    state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [7:0]    shreg, shregNext;
    logic          byteDone, frameBad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= uartRx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bitIdxNext = bitIdx;
        shregNext  = shreg;
        byteDone   = 1'b0;
        frameBad   = 1'b0;
        case (state)
            IDLE: begin
                if (rxPrev && !rxSync) begin
                    stateNext = START;
                    cntNext   = '0;
                end
            end
            START: begin
                // Half-bit recheck aligns all later samples to mid-bit.
                if (cnt == HALF) begin
                    cntNext    = '0;
                    bitIdxNext = '0;
                    stateNext  = rxSync ? IDLE : DATA;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cntNext    = '0;
                    shregNext  = {rxSync, shreg[7:1]};
                    bitIdxNext = bitIdx + 1'b1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cntNext   = '0;
                    stateNext = IDLE;
                    byteDone  = rxSync;
                    frameBad  = !rxSync;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bitIdx     <= '0;
            shreg      <= '0;
            rxByteVld  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            bitIdx     <= bitIdxNext;
            shreg      <= shregNext;
            rxByteVld  <= byteDone;
            rxFrameErr <= frameBad;
        end
    end

    // Shift register is stable from the last data bit until the next frame's first data bit.
    assign rxByte = shreg;
endmodule

// File: rtl/uart_port.sv
// ALU-facing UART: 8N1 TX serializer, RX deserializer, 1-byte RX holding register with read ack.
// TX start bit the cycle after accept, ready low 10 bit times; RX byte acked the cycle after req meets a held byte.
module uart_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uartRx,
    output logic       uartTx,
    input  logic       uartReadReq,
    output logic       uartReadAck,
    output logic [7:0] uartData,
    input  logic       uartWriteReq,
    input  logic [7:0] uartWriteData,
    output logic       uartWriteReady,
    output logic       rxFrameError,
    output logic       rxOverrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uartState_t    txState, txStateNext;
    logic [CW-1:0] txCnt, txCntNext;
    logic [2:0]    txBitIdx, txBitIdxNext;
    logic [7:0]    txShreg, txShregNext;

    logic [7:0] rxByte;
    logic       rxByteVld, rxFrameErr;
    logic [7:0] rxHold;
    logic       rxHoldVld;
    logic       readTake;

    uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxDeser (
        .clk        (clk),
        .reset      (reset),
        .uartRx     (uartRx),
        .rxByte     (rxByte),
        .rxByteVld  (rxByteVld),
        .rxFrameErr (rxFrameErr)
    );

    always_comb begin
        txStateNext  = txState;
        txCntNext    = txCnt;
        txBitIdxNext = txBitIdx;
        txShregNext  = txShreg;
        case (txState)
            IDLE: begin
                if (uartWriteReq) begin
                    txShregNext = uartWriteData;
                    txCntNext   = '0;
                    txStateNext = START;
                end
            end
            START: begin
                if (txCnt == LAST) begin
                    txCntNext    = '0;
                    txBitIdxNext = '0;
                    txStateNext  = DATA;
                end else begin
                    txCntNext = txCnt + 1'b1;
                end
            end
            DATA: begin
                if (txCnt == LAST) begin
                    txCntNext    = '0;
                    txShregNext  = {1'b1, txShreg[7:1]};
                    txBitIdxNext = txBitIdx + 1'b1;
                    if (txBitIdx == 3'd7) txStateNext = STOP;
                end else begin
                    txCntNext = txCnt + 1'b1;
                end
            end
            STOP: begin
                if (txCnt == LAST) begin
                    txCntNext   = '0;
                    txStateNext = IDLE;
                end else begin
                    txCntNext = txCnt + 1'b1;
                end
            end
            default: txStateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState  <= IDLE;
            txCnt    <= '0;
            txBitIdx <= '0;
            txShreg  <= '0;
        end else begin
            txState  <= txStateNext;
            txCnt    <= txCntNext;
            txBitIdx <= txBitIdxNext;
            txShreg  <= txShregNext;
        end
    end

    always_comb begin
        uartTx = 1'b1;
        case (txState)
            START:   uartTx = 1'b0;
            DATA:    uartTx = txShreg[0];
            default: uartTx = 1'b1;
        endcase
    end

    assign uartWriteReady = (txState == IDLE);

    // Gating on the current ack guarantees an idle cycle between consecutive acks.
    assign readTake = uartReadReq && rxHoldVld && !uartReadAck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxHold       <= '0;
            rxHoldVld    <= 1'b0;
            uartReadAck  <= 1'b0;
            uartData     <= '0;
            rxFrameError <= 1'b0;
            rxOverrun    <= 1'b0;
        end else begin
            uartReadAck <= readTake;
            if (readTake) uartData <= rxHold;
            if (rxByteVld) begin
                if (!rxHoldVld || readTake) begin
                    rxHold    <= rxByte;
                    rxHoldVld <= 1'b1;
                end else begin
                    rxOverrun <= 1'b1;
                end
            end else if (readTake) begin
                rxHoldVld <= 1'b0;
            end
            if (rxFrameErr) rxFrameError <= 1'b1;
        end
    end
endmodule
